// File: rtl/shift_pattern_checker.sv
// shift_pattern_checker: monitors a bouncing walking-one bus and decodes
// the set-bit index and travel direction. It locks onto the bounce sequence
// and flags samples that break it while locked.
// Optional feature macro: SHIFT_CHK_ERRCNT_EN enables the saturating
// violation counter. When the macro is not defined, err_count is tied to 0.
module shift_pattern_checker #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         pattern_in,
  input  logic                     valid_in,
  output logic [$clog2(WIDTH)-1:0] position,
  output logic                     dir,
  output logic                     locked,
  output logic                     error,
  output logic [7:0]               err_count
);

  localparam int unsigned PW = $clog2(WIDTH);
  localparam int unsigned CW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             dir_known_q, dir_known_d;
  logic [CW-1:0]    good_q, good_d;
  logic [PW-1:0]    position_q, position_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;

  logic             onehot_c;
  logic [PW-1:0]    idx_c;
  logic             match_up_c;
  logic             match_dn_c;
  logic             match_c;
  logic             prev_msb_c;
  logic             prev_lsb_c;

  // Decode the sample: one-hot test and bit index
  always_comb begin
    onehot_c = (pattern_in != '0) &&
               ((pattern_in & (pattern_in - WIDTH'(1))) == '0);
    idx_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pattern_in[i]) idx_c = PW'(i);
    end
  end

  // Compare the sample against the legal successors of the previous one
  always_comb begin
    prev_msb_c = prev_q[WIDTH-1];
    prev_lsb_c = prev_q[0];
    // An endpoint forces the bounce; otherwise follow dir, or allow both
    // neighbours while the direction is still unknown.
    match_up_c = (pattern_in == (prev_q << 1)) && !prev_msb_c &&
                 (prev_lsb_c || !dir_known_q || dir_q);
    match_dn_c = (pattern_in == (prev_q >> 1)) && !prev_lsb_c &&
                 (prev_msb_c || !dir_known_q || !dir_q);
    match_c    = match_up_c || match_dn_c;
  end

`ifdef SHIFT_CHK_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
`endif

  // Next-state and output logic; only valid samples advance anything
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    dir_known_d = dir_known_q;
    good_d      = good_q;
    position_d  = position_q;
    dir_d       = dir_q;
    locked_d    = locked_q;
    error_d     = 1'b0;
`ifdef SHIFT_CHK_ERRCNT_EN
    err_cnt_d   = err_cnt_q;
`endif

    if (valid_in) begin
      case (state_q)
        ST_HUNT: begin
          if (onehot_c) begin
            // Seed: no arrival direction exists yet, so dir holds
            state_d     = ST_ACQUIRE;
            prev_d      = pattern_in;
            position_d  = idx_c;
            dir_known_d = pattern_in[0] | pattern_in[WIDTH-1];
            good_d      = '0;
          end
        end

        ST_ACQUIRE: begin
          if (match_c) begin
            prev_d      = pattern_in;
            position_d  = idx_c;
            dir_d       = match_up_c;
            dir_known_d = 1'b1;
            if (good_q == CW'(LOCK_CNT - 1)) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              good_d   = '0;
            end else begin
              good_d = good_q + CW'(1);
            end
          end else if (onehot_c) begin
            prev_d      = pattern_in;
            position_d  = idx_c;
            dir_known_d = pattern_in[0] | pattern_in[WIDTH-1];
            good_d      = '0;
          end else begin
            state_d = ST_HUNT;
          end
        end

        ST_LOCKED: begin
          if (match_c) begin
            prev_d     = pattern_in;
            position_d = idx_c;
            dir_d      = match_up_c;
          end else begin
            error_d  = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
`ifdef SHIFT_CHK_ERRCNT_EN
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
            if (onehot_c) begin
              state_d     = ST_ACQUIRE;
              prev_d      = pattern_in;
              position_d  = idx_c;
              dir_known_d = pattern_in[0] | pattern_in[WIDTH-1];
            end else begin
              state_d = ST_HUNT;
            end
          end
        end

        default: begin
          state_d  = ST_HUNT;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      prev_q      <= WIDTH'(1);
      dir_known_q <= 1'b0;
      good_q      <= '0;
      position_q  <= '0;
      dir_q       <= 1'b1;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      dir_known_q <= dir_known_d;
      good_q      <= good_d;
      position_q  <= position_d;
      dir_q       <= dir_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
    end
  end

`ifdef SHIFT_CHK_ERRCNT_EN
  // Saturating violation counter
  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end
  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

  assign position = position_q;
  assign dir      = dir_q;
  assign locked   = locked_q;
  assign error    = error_q;

endmodule
